// File: rtl/pixel_writer.sv
// pixel_writer: FIFO-buffered frame-store writer with double-buffer bank swap; define PIXEL_CLIP_EN to drop off-screen pixels.
// Latency 2 cycles pixel_in_flag->mem_we; mem_we held until mem_ack; a full FIFO drops the pixel and sets sticky overflow.
module pixel_writer #(
   parameter int FIFO_DEPTH = 16,
   parameter int H_RES      = 640,
   parameter int V_RES      = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [17:0] pixel_in,
   input  logic [9:0]  pixel_x,
   input  logic [8:0]  pixel_y,
   input  logic        pixel_in_flag,
   input  logic        frame_flag,
   output logic [19:0] mem_addr,
   output logic [17:0] mem_data,
   output logic        mem_we,
   input  logic        mem_ack,
   output logic        display_bank,
   output logic        overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;
   localparam logic [31:0] H_LIM = H_RES;
   localparam logic [31:0] V_LIM = V_RES;

   typedef struct packed {
      logic        bank;
      logic [18:0] addr;
      logic [17:0] pix;
   } entry_t;

   typedef enum logic {IDLE, WRITE} state_t;

   entry_t      fifo_mem [FIFO_DEPTH];
   entry_t      push_entry;
   entry_t      head;
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] swap_marker;
   logic        write_bank;
   logic        swap_pending;
   state_t      state;
   state_t      state_nxt;
   logic        fifo_empty;
   logic        fifo_full;
   logic        in_frame;
   logic        pix_ok;
   logic        push;
   logic        pop;
   logic        swap_take;
   logic        swap_done;
   logic        bank_nxt;
   logic [18:0] pix_addr;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign in_frame = ({22'd0, pixel_x} < H_LIM) && ({23'd0, pixel_y} < V_LIM);
`ifdef PIXEL_CLIP_EN
   assign pix_ok = in_frame;
`else
   logic unused_in_frame;
   assign unused_in_frame = in_frame;
   assign pix_ok = 1'b1;
`endif

   // Row-major address, deliberately truncated to the 19-bit bank span.
   assign pix_addr = 19'(pixel_y) * 19'(H_RES) + 19'(pixel_x);

   assign pop       = (state == IDLE) && !fifo_empty;
   assign push      = pixel_in_flag && pix_ok && (!fifo_full || pop);
   assign swap_take = frame_flag && !swap_pending;
   assign bank_nxt  = swap_take ? ~write_bank : write_bank;
   // Old frame is fully written once the reader reaches the marker with nothing in flight.
   assign swap_done = swap_pending && (rd_ptr == swap_marker) && (state == IDLE) && !pop;

   assign push_entry = '{bank: bank_nxt, addr: pix_addr, pix: pixel_in};
   assign head       = fifo_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[AW-1:0]] <= push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (pop) state_nxt = WRITE;
         WRITE:   if (mem_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
      end else if (pop) begin
         mem_we   <= 1'b1;
         mem_addr <= {head.bank, head.addr};
         mem_data <= head.pix;
      end else if ((state == WRITE) && mem_ack) begin
         mem_we <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         swap_marker  <= '0;
         write_bank   <= 1'b0;
         display_bank <= 1'b1;
         swap_pending <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         if (pixel_in_flag && pix_ok && !push) overflow <= 1'b1;
         if (swap_done) begin
            display_bank <= ~write_bank;
            swap_pending <= 1'b0;
         end else if (swap_take) begin
            write_bank   <= ~write_bank;
            swap_marker  <= wr_ptr;
            swap_pending <= 1'b1;
         end
      end
   end
endmodule
